// File: rtl/port_array_serializer_if.sv
// Handshake bundle for port_array_serializer: a parallel array input and a serialized element output.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface port_array_serializer_if #(
    parameter int nports = 2,
    parameter int nbits  = 32
);
    localparam int iw = (nports > 1) ? $clog2(nports) : 1;

    logic [nbits-1:0] in_ [nports];
    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] out;
    logic             out_val;
    logic             out_rdy;
    logic [iw-1:0]    out_idx;
    logic             out_last;

    modport slave (
        input  in_, in_val, out_rdy,
        output in_rdy, out, out_val, out_idx, out_last
    );

    modport master (
        output in_, in_val, out_rdy,
        input  in_rdy, out, out_val, out_idx, out_last
    );
endinterface

// File: rtl/port_array_serializer.sv
// Captures an nports-element array in one handshake and emits it one element per out transfer.
// Optional macro PORT_ARRAY_SERIALIZER_PIPE_EN lets a new array load on the last out transfer.
module port_array_serializer #(
    parameter int nports = 2,
    parameter int nbits  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    port_array_serializer_if.slave  bus
);
    localparam int            iw       = (nports > 1) ? $clog2(nports) : 1;
    localparam logic [iw-1:0] last_idx = iw'(nports - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [iw-1:0]    idx_reg, idx_next;
    logic [nbits-1:0] buf_reg [nports];
    logic             at_last;
    logic             in_fire;
    logic             out_fire;
    logic             load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Clearing the buffer on reset guarantees a discarded array can never resurface.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < nports; i++) buf_reg[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < nports; i++) buf_reg[i] <= bus.in_[i];
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        load         = 1'b0;
        at_last      = (idx_reg == last_idx);
        bus.out_val  = (state_reg == BUSY);
        bus.out_idx  = bus.out_val ? idx_reg : '0;
        bus.out_last = bus.out_val && at_last;
        bus.out      = '0;
`ifdef PORT_ARRAY_SERIALIZER_PIPE_EN
        bus.in_rdy   = (state_reg == IDLE) || ((state_reg == BUSY) && at_last && bus.out_rdy);
`else
        bus.in_rdy   = (state_reg == IDLE);
`endif
        in_fire      = bus.in_val && bus.in_rdy;
        out_fire     = bus.out_val && bus.out_rdy;

        if (bus.out_val) begin
            for (int i = 0; i < nports; i++) begin
                if (idx_reg == iw'(i)) bus.out = buf_reg[i];
            end
        end

        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (out_fire) begin
                    if (at_last) begin
                        idx_next = '0;
                        // in_fire here is only possible with the pipelined in_rdy path.
                        if (in_fire) begin
                            load       = 1'b1;
                            state_next = BUSY;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + iw'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end
endmodule
